pwm_generator: RTL

Downstream consumer of the register file's atomically committed LED block (register_led, 512 bits) and the MODE1/MODE2/PRE_SCALE bytes. Runs the PCA9685 prescaler and 12-bit PWM counter, and compares each channel's ON/OFF values against the count. Drives 16 registered PWM outputs toward the pin stage.

---
 rtl/pwm_generator_pkg.sv | 19 +
 rtl/pwm_channel_compare.sv | 41 ++++
 rtl/pwm_generator.sv | 94 +++++++++
 3 files changed

// File: rtl/pwm_generator_pkg.sv
// PCA9685 LED register layout constants shared by the PWM generator and its channel comparators.
package pwm_generator_pkg;

    localparam int LED_CH_BITS  = 32;
    localparam int LED_ON_L     = 0;
    localparam int LED_ON_H     = 1;
    localparam int LED_OFF_L    = 2;
    localparam int LED_OFF_H    = 3;
    localparam int LED_FULL_BIT = 4;

    localparam logic [11:0] COUNTER_MAX  = 12'hFFF;
    localparam logic [7:0]  PRESCALE_MIN = 8'd3;

    // Byte 0 (ON_L) sits in the most significant byte of a channel slice.
    function automatic logic [7:0] led_byte(input logic [31:0] ch, input int idx);
        return ch[31 - 8*idx -: 8];
    endfunction

endpackage

// File: rtl/pwm_channel_compare.sv
// Per-channel ON/OFF field decode and PCA9685 priority compare against the PWM count.
// Purely combinational; no latency, no backpressure.
module pwm_channel_compare
    import pwm_generator_pkg::*;
(
    input  logic [31:0] ch_dat,
    input  logic [11:0] count,
    output logic        pwm_dat
);

    logic [7:0]  on_h;
    logic [7:0]  off_h;
    logic [11:0] on_val;
    logic [11:0] off_val;
    logic        full_on;
    logic        full_off;

    assign on_h     = led_byte(ch_dat, LED_ON_H);
    assign off_h    = led_byte(ch_dat, LED_OFF_H);
    assign on_val   = {on_h[3:0], led_byte(ch_dat, LED_ON_L)};
    assign off_val  = {off_h[3:0], led_byte(ch_dat, LED_OFF_L)};
    assign full_on  = on_h[LED_FULL_BIT];
    assign full_off = off_h[LED_FULL_BIT];

    always_comb begin
        pwm_dat = 1'b0;
        if (full_off) begin
            pwm_dat = 1'b0;
        end else if (full_on) begin
            pwm_dat = 1'b1;
        end else if (on_val == off_val) begin
            pwm_dat = 1'b0;
        end else if (on_val < off_val) begin
            pwm_dat = (count >= on_val) && (count < off_val);
        end else begin
            // ON > OFF: the high window wraps through count 0.
            pwm_dat = (count >= on_val) || (count < off_val);
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// PCA9685 prescaler, 12-bit PWM counter and 16 registered channel outputs; pwm_o lags count_o by one clock.
// Optional PWM_CYCLE_LATCH_EN: LED parameters are shadowed and only take effect at period start.
module pwm_generator
    import pwm_generator_pkg::*;
#(
    parameter int NUM_CHANNELS  = 16,
    parameter int COUNTER_WIDTH = 12,
    parameter int PRESCALE_MIN  = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [0:32*NUM_CHANNELS-1]      register_led_i,
    input  logic [7:0]                      prescale_i,
    input  logic                            sleep_i,
    input  logic                            invert_i,
    output logic [NUM_CHANNELS-1:0]         pwm_o,
    output logic [COUNTER_WIDTH-1:0]        count_o,
    output logic                            cycle_start_o
);

    localparam int LED_W = 32 * NUM_CHANNELS;
    localparam logic [7:0] P_MIN = 8'(PRESCALE_MIN);

    logic [7:0]              presc_cnt;
    logic [7:0]              presc_eff;
    logic                    tick;
    logic                    wrap;
    logic [0:LED_W-1]        led_cmp;
    logic [NUM_CHANNELS-1:0] decision;

    assign presc_eff = (prescale_i < P_MIN) ? P_MIN : prescale_i;
    // >= rather than == so a prescale drop below the running count ticks next clock.
    assign tick      = (presc_cnt >= presc_eff);
    assign wrap      = tick && (count_o == {COUNTER_WIDTH{1'b1}});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_cnt     <= '0;
            count_o       <= '0;
            cycle_start_o <= 1'b0;
        end else if (sleep_i) begin
            presc_cnt     <= '0;
            count_o       <= '0;
            cycle_start_o <= 1'b0;
        end else begin
            cycle_start_o <= wrap;
            if (tick) begin
                presc_cnt <= '0;
                count_o   <= count_o + 1'b1;
            end else begin
                presc_cnt <= presc_cnt + 8'd1;
            end
        end
    end

`ifdef PWM_CYCLE_LATCH_EN
    logic [0:LED_W-1] led_shadow;
    logic             load_first;

    // Loaded together with the count returning to 0 so the new period compares against fresh values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_shadow <= '0;
            load_first <= 1'b1;
        end else begin
            load_first <= 1'b0;
            if (load_first || wrap || sleep_i) begin
                led_shadow <= register_led_i;
            end
        end
    end

    assign led_cmp = led_shadow;
`else
    assign led_cmp = register_led_i;
`endif

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        pwm_channel_compare u_cmp (
            .ch_dat  (led_cmp[32*g +: 32]),
            .count   (count_o),
            .pwm_dat (decision[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_o <= '0;
        end else begin
            pwm_o <= (decision & {NUM_CHANNELS{~sleep_i}}) ^ {NUM_CHANNELS{invert_i}};
        end
    end

endmodule
